// File: rtl/out_port_scheduler.sv
// Per-output-port wormhole scheduler.
// A round-robin arbiter picks one input buffer and holds the grant for a
// whole packet of PKT_FLITS flits. It also tracks downstream credits and
// drives the per-flit transfer strobe and the crossbar select.
// Optional feature macro: OPS_CREDIT_CHECK_EN enables a sticky
// credit-overflow flag on err_o. Without it, err_o is tied low.
module out_port_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int PKT_FLITS  = 4,
    parameter int CREDIT_MAX = 4,
    parameter int SEL_W      = $clog2(NUM_REQ),
    parameter int CNT_W      = $clog2(CREDIT_MAX + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               credit_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               flit_xfer_o,
    output logic               pkt_end_o,
    output logic [CNT_W-1:0]   credit_cnt_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam int FC_W = (PKT_FLITS > 2) ? $clog2(PKT_FLITS) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]         state_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [SEL_W-1:0]   sel_r;
    logic [SEL_W-1:0]   ptr_r;
    logic [FC_W-1:0]    flit_cnt_r;
    logic [CNT_W-1:0]   credit_r;

    logic               pick_found_s;
    logic [SEL_W-1:0]   pick_idx_s;
    logic [SEL_W:0]     cand_s;
    logic [SEL_W-1:0]   ptr_next_s;
    logic               xfer_s;
    logic               last_s;
    logic [CNT_W-1:0]   credit_nxt_s;

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = {1'b0, ptr_r} + (SEL_W+1)'(i);
            if (cand_s >= (SEL_W+1)'(NUM_REQ)) begin
                cand_s = cand_s - (SEL_W+1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!pick_found_s && req_i[cand_s[SEL_W-1:0]]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s[SEL_W-1:0];
            end else begin
                pick_found_s = pick_found_s;
                pick_idx_s   = pick_idx_s;
            end
        end
    end

    // Next pointer after a packet ends: one past the owner, wrapping.
    always_comb begin
        if (sel_r == SEL_W'(NUM_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = sel_r + SEL_W'(1);
        end
    end

    // A flit moves only while locked, the owner still requests and a credit exists.
    always_comb begin
        xfer_s = (state_r == ST_LOCKED) && req_i[sel_r] && (credit_r != CNT_W'(0));
        last_s = (flit_cnt_r == FC_W'(PKT_FLITS - 1));
    end

    // Credit update: consume on transfer, refund on credit_i, saturate at the top.
    always_comb begin
        credit_nxt_s = credit_r;
        case ({xfer_s, credit_i})
            2'b10:   credit_nxt_s = credit_r - CNT_W'(1);
            2'b01:   credit_nxt_s = (credit_r == CNT_W'(CREDIT_MAX)) ? credit_r
                                                                     : credit_r + CNT_W'(1);
            default: credit_nxt_s = credit_r;
        endcase
    end

    // Credit counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_r <= CNT_W'(CREDIT_MAX);
        end else begin
            credit_r <= credit_nxt_s;
        end
    end

    // Arbitration / packet-lock state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            sel_r      <= '0;
            ptr_r      <= '0;
            flit_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_r <= ST_LOCKED;
                        grant_r <= NUM_REQ'(1) << pick_idx_s;
                        sel_r   <= pick_idx_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (xfer_s && last_s) begin
                        state_r    <= ST_IDLE;
                        grant_r    <= '0;
                        flit_cnt_r <= '0;
                        ptr_r      <= ptr_next_s;
                    end else if (xfer_s) begin
                        flit_cnt_r <= flit_cnt_r + FC_W'(1);
                    end else begin
                        flit_cnt_r <= flit_cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    grant_r    <= '0;
                    flit_cnt_r <= '0;
                end
            endcase
        end
    end

`ifdef OPS_CREDIT_CHECK_EN
    logic err_r;

    // Sticky flag: a credit returned while already full and not being consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (credit_i && (credit_r == CNT_W'(CREDIT_MAX)) && !xfer_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

    assign grant_o      = grant_r;
    assign sel_o        = sel_r;
    assign flit_xfer_o  = xfer_s;
    assign pkt_end_o    = xfer_s && last_s;
    assign credit_cnt_o = credit_r;
    assign busy_o       = (state_r == ST_LOCKED);

endmodule

// File: tb/tb_out_port_scheduler.sv
// Directed self-checking bench for out_port_scheduler (default parameters).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_out_port_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_i;
    logic       credit_i;
    logic [3:0] grant_o;
    logic [1:0] sel_o;
    logic       flit_xfer_o;
    logic       pkt_end_o;
    logic [2:0] credit_cnt_o;
    logic       busy_o;
    logic       err_o;

    int checks_total  = 0;
    int checks_passed = 0;

    out_port_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req_i),
        .credit_i     (credit_i),
        .grant_o      (grant_o),
        .sel_o        (sel_o),
        .flit_xfer_o  (flit_xfer_o),
        .pkt_end_o    (pkt_end_o),
        .credit_cnt_o (credit_cnt_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks_total++;
        if (obs == exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req_i    = 4'b0000;
        credit_i = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    int exp_err;

    initial begin
`ifdef OPS_CREDIT_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        // ---- Test 1: single requester, full packet drains the credits
        do_reset();
        #1;
        check_eq("rst_grant",  grant_o, 0);
        check_eq("rst_sel",    sel_o, 0);
        check_eq("rst_credit", credit_cnt_o, 4);
        check_eq("rst_busy",   busy_o, 0);
        check_eq("rst_xfer",   flit_xfer_o, 0);
        check_eq("rst_pktend", pkt_end_o, 0);
        check_eq("rst_err",    err_o, 0);
        req_i = 4'b0010;
        #1;
        check_eq("t1_idle_xfer", flit_xfer_o, 0);
        step();
        check_eq("t1_grant", grant_o, 2);
        check_eq("t1_sel",   sel_o, 1);
        check_eq("t1_busy",  busy_o, 1);
        for (int f = 0; f < 4; f++) begin
            #1;
            check_eq("t1_xfer",   flit_xfer_o, 1);
            check_eq("t1_pktend", pkt_end_o, (f == 3) ? 1 : 0);
            check_eq("t1_credit", credit_cnt_o, 4 - f);
            step();
        end
        req_i = 4'b0000;
        #1;
        check_eq("t1_end_grant",  grant_o, 0);
        check_eq("t1_end_busy",   busy_o, 0);
        check_eq("t1_end_credit", credit_cnt_o, 0);
        check_eq("t1_end_xfer",   flit_xfer_o, 0);

        // ---- Test 4: no credits left, next packet granted but stalls
        req_i = 4'b0001;
        step();
        #1;
        check_eq("t4_grant", grant_o, 1);
        check_eq("t4_stall", flit_xfer_o, 0);
        step();
        check_eq("t4_stall2", flit_xfer_o, 0);
        credit_i = 1'b1;
        #1;
        check_eq("t4_stall_at_credit", flit_xfer_o, 0);
        step();
        credit_i = 1'b0;
        #1;
        check_eq("t4_credit1", credit_cnt_o, 1);
        check_eq("t4_one_xfer", flit_xfer_o, 1);
        step();
        check_eq("t4_credit0", credit_cnt_o, 0);
        check_eq("t4_no_more", flit_xfer_o, 0);
        check_eq("t4_grant_kept", grant_o, 1);

        // ---- Test 2: all requesting, credit returned every flit
        do_reset();
        req_i = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            credit_i = 1'b0;
            #1;
            check_eq("t2_idle_grant", grant_o, 0);
            check_eq("t2_idle_busy",  busy_o, 0);
            step();
            check_eq("t2_grant", grant_o, 1 << (p % 4));
            check_eq("t2_sel",   sel_o, p % 4);
            for (int f = 0; f < 4; f++) begin
                credit_i = 1'b1;
                #1;
                check_eq("t2_xfer",   flit_xfer_o, 1);
                check_eq("t2_pktend", pkt_end_o, (f == 3) ? 1 : 0);
                check_eq("t2_credit", credit_cnt_o, 4);
                step();
            end
        end
        credit_i = 1'b0;

        // ---- Test 3: owner 2 stalls mid-packet, lock is held
        do_reset();
        req_i = 4'b0100;
        step();
        check_eq("t3_grant", grant_o, 4);
        req_i = 4'b0101;
        for (int f = 0; f < 2; f++) begin
            #1;
            check_eq("t3_xfer_a", flit_xfer_o, 1);
            step();
        end
        req_i = 4'b0001;
        for (int s = 0; s < 3; s++) begin
            #1;
            check_eq("t3_stall_xfer",  flit_xfer_o, 0);
            check_eq("t3_stall_grant", grant_o, 4);
            check_eq("t3_stall_credit", credit_cnt_o, 2);
            step();
        end
        req_i = 4'b0101;
        for (int f = 2; f < 4; f++) begin
            #1;
            check_eq("t3_xfer_b",  flit_xfer_o, 1);
            check_eq("t3_pktend",  pkt_end_o, (f == 3) ? 1 : 0);
            step();
        end
        req_i = 4'b0001;
        #1;
        check_eq("t3_idle_grant", grant_o, 0);
        step();
        check_eq("t3_next_grant", grant_o, 1);
        check_eq("t3_next_sel",   sel_o, 0);

        // ---- Test 5: reset in the middle of a packet
        do_reset();
        req_i = 4'b1111;
        step();
        check_eq("t5_grant", grant_o, 1);
        step();
        step();
        check_eq("t5_mid_credit", credit_cnt_o, 2);
        reset = 1'b1;
        step();
        check_eq("t5_rst_grant",  grant_o, 0);
        check_eq("t5_rst_credit", credit_cnt_o, 4);
        check_eq("t5_rst_busy",   busy_o, 0);
        reset = 1'b0;
        step();
        check_eq("t5_regrant", grant_o, 1);
        check_eq("t5_resel",   sel_o, 0);

        // ---- Test 6: credit return while already full
        do_reset();
        credit_i = 1'b1;
        step();
        credit_i = 1'b0;
        #1;
        check_eq("t6_err",    err_o, exp_err);
        check_eq("t6_credit", credit_cnt_o, 4);
        step();
        step();
        check_eq("t6_err_sticky", err_o, exp_err);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
